// File: rtl/id_ex_issue_if.sv
// ID/EX issue bus: decode-side inputs and the registered EX-stage controls.
// master = decode/issue stage (drives ex_*), slave = EX stage / environment.
interface id_ex_issue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
);
    logic [XLEN-1:0]  id_instr;
    logic             id_valid;
    logic [XLEN-1:0]  id_rs_data;
    logic [XLEN-1:0]  id_rt_data;
    logic             flush;
    logic             stall_if;
    logic             ex_valid;
    logic [1:0]       ex_alu_op;
    logic [5:0]       ex_func;
    logic [4:0]       ex_shamt;
    logic [XLEN-1:0]  ex_a;
    logic [XLEN-1:0]  ex_b;
    logic [XLEN-1:0]  ex_rt_data;
    logic [RADDR-1:0] ex_write_reg;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_branch;
    logic             illegal_instr;

    modport master (
        input  id_instr, id_valid, id_rs_data, id_rt_data, flush,
        output stall_if, ex_valid, ex_alu_op, ex_func, ex_shamt, ex_a, ex_b, ex_rt_data,
               ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, illegal_instr
    );

    modport slave (
        output id_instr, id_valid, id_rs_data, id_rt_data, flush,
        input  stall_if, ex_valid, ex_alu_op, ex_func, ex_shamt, ex_a, ex_b, ex_rt_data,
               ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, illegal_instr
    );
endinterface

// File: rtl/id_ex_issue.sv
// Decode stage + ID/EX pipeline register with load-use hazard bubble and branch flush.
// Optional: define ISSUE_ADDI_EN to decode opcode 0x08 (addi); otherwise it is illegal.
module id_ex_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_issue_if.master bus
);
    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StStall = 1'b1;

    logic [0:0] state_q, state_d;

    logic [5:0]       opcode;
    logic [4:0]       rs, rt, rd;
    logic [XLEN-1:0]  imm_sext;

    logic             legal, alu_src, reg_write, mem_read, mem_write, branch;
    logic             use_rs, use_rt;
    logic [1:0]       alu_op;
    logic [RADDR-1:0] dst;
    logic             load_use, issue, illegal_d;

    assign opcode   = bus.id_instr[31:26];
    assign rs       = bus.id_instr[25:21];
    assign rt       = bus.id_instr[20:16];
    assign rd       = bus.id_instr[15:11];
    assign imm_sext = {{(XLEN-16){bus.id_instr[15]}}, bus.id_instr[15:0]};

    // Opcode decode: controls plus which source fields the instruction really reads.
    always_comb begin
        legal     = 1'b1;
        alu_op    = 2'b00;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        dst       = '0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        unique case (opcode)
            6'h00: begin
                alu_op    = 2'b10;
                reg_write = 1'b1;
                dst       = RADDR'(rd);
                // Shifts by shamt (sll/srl) ignore the rs field.
                use_rs    = !(bus.id_instr[5:0] == 6'd0 || bus.id_instr[5:0] == 6'd2);
                use_rt    = 1'b1;
            end
            6'h23: begin
                alu_src   = 1'b1;
                mem_read  = 1'b1;
                reg_write = 1'b1;
                dst       = RADDR'(rt);
                use_rs    = 1'b1;
            end
            6'h2B: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                use_rs    = 1'b1;
                use_rt    = 1'b1;
            end
            6'h04: begin
                alu_op    = 2'b01;
                branch    = 1'b1;
                use_rs    = 1'b1;
                use_rt    = 1'b1;
            end
`ifdef ISSUE_ADDI_EN
            6'h08: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                dst       = RADDR'(rt);
                use_rs    = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Load-use detection and issue qualification; flush overrides everything.
    always_comb begin
        load_use = (state_q == StRun) && bus.ex_valid && bus.ex_mem_read &&
                   (bus.ex_write_reg != '0) && bus.id_valid && !bus.flush &&
                   ((use_rs && (RADDR'(rs) == bus.ex_write_reg)) ||
                    (use_rt && (RADDR'(rt) == bus.ex_write_reg)));
        issue        = bus.id_valid && !bus.flush && !load_use && legal;
        illegal_d    = bus.id_valid && !bus.flush && !legal;
        bus.stall_if = load_use && rst_n;
        state_d      = load_use ? StStall : StRun;
    end

    // Hazard FSM: STALL lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StRun;
        else        state_q <= state_d;
    end

    // ID/EX register: issued instruction or an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_alu_op     <= 2'b00;
            bus.ex_func       <= '0;
            bus.ex_shamt      <= '0;
            bus.ex_a          <= '0;
            bus.ex_b          <= '0;
            bus.ex_rt_data    <= '0;
            bus.ex_write_reg  <= '0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.illegal_instr <= 1'b0;
        end else begin
            bus.illegal_instr <= illegal_d;
            if (issue) begin
                bus.ex_valid     <= 1'b1;
                bus.ex_alu_op    <= alu_op;
                bus.ex_func      <= bus.id_instr[5:0];
                bus.ex_shamt     <= bus.id_instr[10:6];
                bus.ex_a         <= bus.id_rs_data;
                bus.ex_b         <= alu_src ? imm_sext : bus.id_rt_data;
                bus.ex_rt_data   <= bus.id_rt_data;
                bus.ex_write_reg <= dst;
                // Writes to $0 are dropped so NOP is harmless.
                bus.ex_reg_write <= reg_write && (dst != '0);
                bus.ex_mem_read  <= mem_read;
                bus.ex_mem_write <= mem_write;
                bus.ex_branch    <= branch;
            end else begin
                bus.ex_valid     <= 1'b0;
                bus.ex_alu_op    <= 2'b00;
                bus.ex_func      <= '0;
                bus.ex_shamt     <= '0;
                bus.ex_a         <= '0;
                bus.ex_b         <= '0;
                bus.ex_rt_data   <= '0;
                bus.ex_write_reg <= '0;
                bus.ex_reg_write <= 1'b0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_mem_write <= 1'b0;
                bus.ex_branch    <= 1'b0;
            end
        end
    end
endmodule
